core_sequencer: RTL and testbench
=================================

# core_sequencer

Program sequencer for the compute core and its block RAM. It holds a loadable program memory of 17-bit core instruction words with 2-bit flow-control tags. After a start handshake it issues one instruction per cycle to the core's instruction input, running until a HALT tag or an abort. It supports one hardware loop level with a latched repeat count, so a round body can be repeated without duplicating program words.

## Interface
- INSTR_WIDTH, 17, core instruction width: address[16:10], write[9], alu_opcode[8:5], input_select[4:3], output_select[2], output_enable[1], save_core_selection[0]
- PC_WIDTH, 8, program address width; program depth is 2**PC_WIDTH
- LOOP_WIDTH, 8, loop count width

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- prog_we_i  in  1  program write strobe; honoured only when idle
- prog_addr_i  in  PC_WIDTH  program write address
- prog_data_i  in  INSTR_WIDTH+2  [INSTR_WIDTH+1:INSTR_WIDTH] tag, [INSTR_WIDTH-1:0] instruction
- start_i  in  1  start request; honoured only when idle
- start_addr_i  in  PC_WIDTH  first program address, latched on start
- loop_count_i  in  LOOP_WIDTH  extra loop iterations, latched on start
- abort_i  in  1  synchronous abort
- instruction_o  out  INSTR_WIDTH  instruction to core/RAM; all-zero is NOP
- busy_o  out  1  program running
- done_o  out  1  one-cycle pulse on normal HALT completion
- pc_o  out  PC_WIDTH  address of the instruction currently on instruction_o
- loop_remaining_o  out  LOOP_WIDTH  loop iterations remaining

## Operation
- Tags: 00 NORMAL; 01 LOOP_END; 10 HALT; 11 LOOP_BEGIN. The instruction field of every tag is issued to the core.
- Program memory: synchronous write, synchronous read with 1-cycle latency. Not cleared by reset. Writes while busy_o=1 are dropped.
- States:
  - IDLE: instruction_o=0. start_i latches start_addr_i, loop_count_i and the fetch address, then moves to PRIME.
  - PRIME: one bubble cycle with instruction_o=0, then RUN.
  - RUN: issues the fetched word and increments the fetch address each cycle.
- LOOP_BEGIN at address A: loop_start←A+1, loop_remaining←latched loop_count.
- LOOP_END at address B:
  - If loop_remaining≠0: decrement it, set fetch address←loop_start, and discard the in-flight word (B+1), which gives one bubble cycle.
  - If loop_remaining=0: fall through to B+1.
  - The body (A+1..B) therefore executes loop_count+1 times.
- LOOP_END without a prior LOOP_BEGIN in this run uses loop_start=0 and loop_remaining=0, so it falls through.
- HALT: its instruction is issued, and the block returns to IDLE the next cycle.
- abort_i is checked in PRIME or RUN with priority over all tags. It returns to IDLE the next cycle with instruction_o=0 and no done_o. abort_i in IDLE has no effect.
- start_i while busy is ignored. start_i and abort_i together in IDLE: start wins.
- The fetch address wraps from 2**PC_WIDTH-1 to 0; this wrap also applies to loop_start computation.

## Timing
- Reset (async assert, sync-safe release) sets:
  - all outputs to 0
  - state to IDLE
  - loop_remaining and loop_start to 0
- Start handshake (start_i sampled at edge k):
  - busy_o=1 from cycle k+1, the PRIME bubble.
  - The first instruction (start_addr) is on instruction_o in cycle k+2.
- instruction_o, pc_o and loop_remaining_o are registered or derived only from state, with no combinational path from inputs.
- HALT issued in cycle h: busy_o=0 and done_o=1 in cycle h+1; done_o=0 in cycle h+2.
- Taken LOOP_END in cycle t: bubble (instruction_o=0) in t+1; instruction at loop_start in t+2.
- Abort sampled at edge a: instruction_o=0 and busy_o=0 from cycle a+1.
- A new start is accepted in the cycle done_o is high.
- Steady-state throughput is one instruction per cycle, apart from the PRIME bubble and loop-jump bubbles.

## Test plan
- Reset held with random inputs: all outputs 0. Release, then prog_we_i while idle, then write during busy: the busy write is not stored (checked by readback run).
- Program 0x10..0x13 NORMAL with values 1,2,3,4, HALT at 0x14 = 5. start at 0x10: instruction_o shows 0,1,2,3,4,5 on cycles k+1..k+6; done_o pulses at k+7; pc_o tracks 0x10..0x14.
- LOOP_BEGIN at 0x00, body 0x01–0x02, LOOP_END at 0x03, HALT at 0x04, loop_count=2: body issued 3 times, bubble after each taken LOOP_END, loop_remaining_o steps 2→1→0, done_o once.
- abort_i asserted mid-loop: next cycle instruction_o=0 and busy_o=0, no done_o. A restart then reruns from the new start_addr with loop state reloaded.
- start at 0xFE with NORMAL at 0xFE, 0xFF and HALT at 0x00: pc wraps and completes normally. start_i pulsed while busy is ignored.
- start_i and abort_i together in IDLE: run starts. start_i in the done_o cycle: accepted, PRIME next cycle.

Source files
------------

// File: rtl/core_sequencer.sv
// Program sequencer: loadable tagged program memory issuing one core
// instruction per cycle, with a single hardware loop level.
module core_sequencer #(
    parameter int INSTR_WIDTH = 17,
    parameter int PC_WIDTH    = 8,
    parameter int LOOP_WIDTH  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   prog_we_i,
    input  logic [PC_WIDTH-1:0]    prog_addr_i,
    input  logic [INSTR_WIDTH+1:0] prog_data_i,
    input  logic                   start_i,
    input  logic [PC_WIDTH-1:0]    start_addr_i,
    input  logic [LOOP_WIDTH-1:0]  loop_count_i,
    input  logic                   abort_i,
    output logic [INSTR_WIDTH-1:0] instruction_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [PC_WIDTH-1:0]    pc_o,
    output logic [LOOP_WIDTH-1:0]  loop_remaining_o
);

    localparam int WORD_W = INSTR_WIDTH + 2;
    localparam int DEPTH  = 2 ** PC_WIDTH;

    localparam logic [1:0] TAG_LOOP_END   = 2'b01;
    localparam logic [1:0] TAG_HALT       = 2'b10;
    localparam logic [1:0] TAG_LOOP_BEGIN = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   fetch_q, fetch_d;
    logic [PC_WIDTH-1:0]   loop_start_q, loop_start_d;
    logic [LOOP_WIDTH-1:0] loop_rem_q, loop_rem_d;
    logic [LOOP_WIDTH-1:0] count_q, count_d;
    logic                  discard_q, discard_d;
    logic                  done_q, done_d;

    logic [WORD_W-1:0]     mem_q [DEPTH];
    logic [WORD_W-1:0]     rd_q;
    logic [PC_WIDTH-1:0]   rd_pc_q;

    logic                  issue;
    logic [1:0]            tag;

    // Read port always tracks the fetch address; its word is issued next cycle.
    always_ff @(posedge clk_i) begin
        if (prog_we_i && state_q == IDLE) begin
            mem_q[prog_addr_i] <= prog_data_i;
        end
        rd_q    <= mem_q[fetch_q];
        rd_pc_q <= fetch_q;
    end

    assign issue = (state_q == RUN) && !discard_q;
    assign tag   = rd_q[WORD_W-1:INSTR_WIDTH];

    always_comb begin
        state_d      = state_q;
        fetch_d      = fetch_q;
        loop_start_d = loop_start_q;
        loop_rem_d   = loop_rem_q;
        count_d      = count_q;
        discard_d    = 1'b0;
        done_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d      = PRIME;
                    fetch_d      = start_addr_i;
                    count_d      = loop_count_i;
                    loop_start_d = '0;
                    loop_rem_d   = '0;
                end
            end
            PRIME: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                    fetch_d = fetch_q + PC_WIDTH'(1);
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    fetch_d = fetch_q + PC_WIDTH'(1);
                    if (!discard_q) begin
                        unique case (tag)
                            TAG_LOOP_BEGIN: begin
                                loop_start_d = rd_pc_q + PC_WIDTH'(1);
                                loop_rem_d   = count_q;
                            end
                            TAG_LOOP_END: begin
                                // Taken jump: the word already in flight is dropped.
                                if (loop_rem_q != '0) begin
                                    loop_rem_d = loop_rem_q - LOOP_WIDTH'(1);
                                    fetch_d    = loop_start_q;
                                    discard_d  = 1'b1;
                                end
                            end
                            TAG_HALT: begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            fetch_q      <= '0;
            loop_start_q <= '0;
            loop_rem_q   <= '0;
            count_q      <= '0;
            discard_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_q      <= fetch_d;
            loop_start_q <= loop_start_d;
            loop_rem_q   <= loop_rem_d;
            count_q      <= count_d;
            discard_q    <= discard_d;
            done_q       <= done_d;
        end
    end

    assign instruction_o    = issue ? rd_q[INSTR_WIDTH-1:0] : '0;
    assign pc_o             = issue ? rd_pc_q : '0;
    assign busy_o           = (state_q != IDLE);
    assign done_o           = done_q;
    assign loop_remaining_o = loop_rem_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: per-cycle expected outputs
// and the stimulus to apply after each check are queued per scenario.
module tb_core_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        prog_we_i = 1'b0;
    logic [7:0]  prog_addr_i = '0;
    logic [18:0] prog_data_i = '0;
    logic        start_i = 1'b0;
    logic [7:0]  start_addr_i = '0;
    logic [7:0]  loop_count_i = '0;
    logic        abort_i = 1'b0;
    logic [16:0] instruction_o;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  pc_o;
    logic [7:0]  loop_remaining_o;

    core_sequencer dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .prog_we_i        (prog_we_i),
        .prog_addr_i      (prog_addr_i),
        .prog_data_i      (prog_data_i),
        .start_i          (start_i),
        .start_addr_i     (start_addr_i),
        .loop_count_i     (loop_count_i),
        .abort_i          (abort_i),
        .instruction_o    (instruction_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .pc_o             (pc_o),
        .loop_remaining_o (loop_remaining_o)
    );

    always #5 clk_i = ~clk_i;

    // {instruction, pc, busy, done, loop_remaining}
    typedef struct {
        logic [34:0] o;
        bit          st;
        bit          ab;
        bit          we;
        logic [7:0]  sa;
        logic [7:0]  lc;
        logic [7:0]  wa;
        logic [18:0] wd;
    } ent_t;

    ent_t sb[$];
    int   n_run = 0;
    int   n_fail = 0;

    wire [34:0] obs = {instruction_o, pc_o, busy_o, done_o, loop_remaining_o};

    localparam logic [1:0] NRM = 2'b00;
    localparam logic [1:0] LE  = 2'b01;
    localparam logic [1:0] HLT = 2'b10;
    localparam logic [1:0] LB  = 2'b11;

    function automatic void px(
        input logic [16:0] i, input logic [7:0] pc,
        input bit b, input bit d, input logic [7:0] r,
        input bit st = 0, input bit ab = 0,
        input logic [7:0] sa = 0, input logic [7:0] lc = 0,
        input bit we = 0, input logic [7:0] wa = 0,
        input logic [18:0] wd = 0);
        ent_t e;
        e.o  = {i, pc, b, d, r};
        e.st = st;
        e.ab = ab;
        e.we = we;
        e.sa = sa;
        e.lc = lc;
        e.wa = wa;
        e.wd = wd;
        sb.push_back(e);
    endfunction

    task automatic prog(input logic [7:0] a, input logic [1:0] t,
                        input logic [16:0] v);
        prog_we_i   = 1'b1;
        prog_addr_i = a;
        prog_data_i = {t, v};
        @(negedge clk_i);
        prog_we_i   = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            prog_we_i    = 1'($urandom);
            prog_addr_i  = 8'($urandom);
            prog_data_i  = 19'($urandom);
            start_i      = 1'($urandom);
            start_addr_i = 8'($urandom);
            loop_count_i = 8'($urandom);
            abort_i      = 1'($urandom);
            #1;
            n_run++;
            if (obs !== 35'd0) begin
                n_fail++;
                $display("FAIL reset_hold%0d got %h exp %h", i, obs, 35'd0);
            end
        end
        @(negedge clk_i);
        {prog_we_i, start_i, abort_i} = 3'b000;
        rst_n_i = 1'b1;
        @(negedge clk_i);
        n_run++;
        if (obs !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_release got %h exp %h", obs, 35'd0);
        end
    endtask

    task automatic test_linear();
        ent_t e;
        int c = 0;
        for (int i = 0; i < 4; i++) prog(8'(8'h10 + i), NRM, 17'(i + 1));
        prog(8'h14, HLT, 17'd5);
        // start and abort together in IDLE: start wins
        px(0, 0, 0, 0, 0, 1, 1, 8'h10, 8'd0);
        px(0, 0, 1, 0, 0);
        for (int i = 1; i <= 5; i++) px(17'(i), 8'(8'h0F + i), 1, 0, 0);
        px(0, 0, 0, 1, 0);
        px(0, 0, 0, 0, 0);
        while (sb.size() != 0) begin
            @(negedge clk_i);
            e = sb.pop_front();
            n_run++;
            if (obs !== e.o) begin
                n_fail++;
                $display("FAIL linear cyc%0d got %h exp %h", c, obs, e.o);
            end
            c++;
            {start_i, abort_i, prog_we_i} = {e.st, e.ab, e.we};
            {start_addr_i, loop_count_i} = {e.sa, e.lc};
            {prog_addr_i, prog_data_i} = {e.wa, e.wd};
        end
    endtask

    task automatic test_loop();
        ent_t e;
        int c = 0;
        prog(8'h00, LB, 17'h11);
        prog(8'h01, NRM, 17'h12);
        prog(8'h02, NRM, 17'h13);
        prog(8'h03, LE, 17'h14);
        prog(8'h04, HLT, 17'h15);
        px(0, 0, 0, 0, 0, 1, 0, 8'h00, 8'd2);
        px(0, 0, 1, 0, 0);
        px(17'h11, 8'h00, 1, 0, 0);
        for (int r = 2; r >= 0; r--) begin
            px(17'h12, 8'h01, 1, 0, 8'(r));
            px(17'h13, 8'h02, 1, 0, 8'(r));
            px(17'h14, 8'h03, 1, 0, 8'(r));
            if (r != 0) px(0, 0, 1, 0, 8'(r - 1));
        end
        px(17'h15, 8'h04, 1, 0, 0);
        px(0, 0, 0, 1, 0);
        px(0, 0, 0, 0, 0);
        while (sb.size() != 0) begin
            @(negedge clk_i);
            e = sb.pop_front();
            n_run++;
            if (obs !== e.o) begin
                n_fail++;
                $display("FAIL loop cyc%0d got %h exp %h", c, obs, e.o);
            end
            c++;
            {start_i, abort_i, prog_we_i} = {e.st, e.ab, e.we};
            {start_addr_i, loop_count_i} = {e.sa, e.lc};
            {prog_addr_i, prog_data_i} = {e.wa, e.wd};
        end
    endtask

    task automatic test_abort_restart();
        ent_t e;
        int c = 0;
        prog(8'h20, LB, 17'h21);
        prog(8'h21, LE, 17'h22);
        prog(8'h22, HLT, 17'h23);
        px(0, 0, 0, 0, 0, 1, 0, 8'h00, 8'd3);
        px(0, 0, 1, 0, 0);
        px(17'h11, 8'h00, 1, 0, 0);
        px(17'h12, 8'h01, 1, 0, 3);
        px(17'h13, 8'h02, 1, 0, 3);
        px(17'h14, 8'h03, 1, 0, 3);
        px(0, 0, 1, 0, 2);
        px(17'h12, 8'h01, 1, 0, 2, 0, 1);
        px(0, 0, 0, 0, 2);
        px(0, 0, 0, 0, 2, 1, 0, 8'h20, 8'd1);
        px(0, 0, 1, 0, 0);
        px(17'h21, 8'h20, 1, 0, 0);
        px(17'h22, 8'h21, 1, 0, 1);
        px(0, 0, 1, 0, 0);
        px(17'h22, 8'h21, 1, 0, 0);
        px(17'h23, 8'h22, 1, 0, 0);
        px(0, 0, 0, 1, 0);
        px(0, 0, 0, 0, 0);
        while (sb.size() != 0) begin
            @(negedge clk_i);
            e = sb.pop_front();
            n_run++;
            if (obs !== e.o) begin
                n_fail++;
                $display("FAIL abort cyc%0d got %h exp %h", c, obs, e.o);
            end
            c++;
            {start_i, abort_i, prog_we_i} = {e.st, e.ab, e.we};
            {start_addr_i, loop_count_i} = {e.sa, e.lc};
            {prog_addr_i, prog_data_i} = {e.wa, e.wd};
        end
    endtask

    task automatic test_back_to_back();
        ent_t e;
        int c = 0;
        prog(8'h50, HLT, 17'h41);
        prog(8'hFE, NRM, 17'h31);
        prog(8'hFF, LE, 17'h32);
        prog(8'h00, HLT, 17'h33);
        px(0, 0, 0, 0, 0, 1, 0, 8'hFE, 8'd5);
        px(0, 0, 1, 0, 0);
        // start and a program write while busy: both must be ignored
        px(17'h31, 8'hFE, 1, 0, 0, 1, 0, 8'h10, 8'd7,
           1, 8'h50, {HLT, 17'h7F});
        px(17'h32, 8'hFF, 1, 0, 0);
        px(17'h33, 8'h00, 1, 0, 0);
        px(0, 0, 0, 1, 0, 1, 0, 8'h50, 8'd0);
        px(0, 0, 1, 0, 0);
        px(17'h41, 8'h50, 1, 0, 0);
        px(0, 0, 0, 1, 0);
        px(0, 0, 0, 0, 0);
        while (sb.size() != 0) begin
            @(negedge clk_i);
            e = sb.pop_front();
            n_run++;
            if (obs !== e.o) begin
                n_fail++;
                $display("FAIL b2b cyc%0d got %h exp %h", c, obs, e.o);
            end
            c++;
            {start_i, abort_i, prog_we_i} = {e.st, e.ab, e.we};
            {start_addr_i, loop_count_i} = {e.sa, e.lc};
            {prog_addr_i, prog_data_i} = {e.wa, e.wd};
        end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_loop();
        test_abort_restart();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
